// File: rtl/key_debounce_sync.sv
// ============================================================================
// Module   : key_debounce_sync
// Brief    : Push-button conditioner: 2-FF synchronizer, polarity
//            normalization and counter-qualified debounce FSM with
//            registered level plus press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic             c_RAW_IDLE = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ST_RELEASED     = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_PRESSED      = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_pressed;

    assign w_pressed   = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= c_RAW_IDLE;
            r_sync2   <= c_RAW_IDLE;
            r_state   <= c_ST_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= key_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                c_ST_RELEASED: begin
                    r_cnt <= '0;
                    if (w_pressed) begin
                        r_state <= c_ST_PRESS_WAIT;
                    end
                end
                c_ST_PRESS_WAIT: begin
                    if (!w_pressed) begin
                        r_state <= c_ST_RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state <= c_ST_PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_PRESSED: begin
                    r_cnt <= '0;
                    if (!w_pressed) begin
                        r_state <= c_ST_RELEASE_WAIT;
                    end
                end
                c_ST_RELEASE_WAIT: begin
                    if (w_pressed) begin
                        r_state <= c_ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state   <= c_ST_RELEASED;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // Unreachable with a 2-bit encoding; kept as a safe recovery path
                    r_state <= c_ST_RELEASED;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_sync.sv
// ============================================================================
// Module   : tb_key_debounce_sync
// Brief    : Scoreboard bench for key_debounce_sync, both polarities driven
//            with the same logical button activity against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce_sync;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset;
    logic key_p;          // logical "button held" stimulus
    logic raw_al;
    logic raw_ah;
    logic lvl_al, prs_al, rel_al;
    logic lvl_ah, prs_ah, rel_ah;

    assign raw_al = ~key_p;
    assign raw_ah = key_p;

    always #5 clk = ~clk;

    key_debounce_sync #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .ACTIVE_LOW(1)) u_dut_al (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (raw_al),
        .key_level   (lvl_al),
        .key_press   (prs_al),
        .key_release (rel_al)
    );

    key_debounce_sync #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .ACTIVE_LOW(0)) u_dut_ah (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (raw_ah),
        .key_level   (lvl_ah),
        .key_press   (prs_ah),
        .key_release (rel_ah)
    );

    // Model: the FSM sees the input two edges late; the level flips once the
    // delayed input has disagreed with it on DEB+1 consecutive edges.
    logic   m_h1, m_h2, m_level;
    int     m_run;
    logic [2:0] exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic drive(input logic p, input logic r);
        logic s;
        logic [2:0] e;
        key_p = p;
        reset = r;
        e = 3'b000;
        if (r) begin
            m_h1 = 1'b0; m_h2 = 1'b0; m_level = 1'b0; m_run = 0;
        end else begin
            s    = m_h2;
            m_h2 = m_h1;
            m_h1 = p;
            if (s != m_level) begin
                m_run = m_run + 1;
                if (m_run == DEB + 1) begin
                    m_level = s;
                    e[1]    = s;
                    e[0]    = ~s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        e[2] = m_level;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic p, input int n);
        for (int i = 0; i < n; i++) drive(p, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({lvl_al, prs_al, rel_al} !== e) begin
                n_errors++;
                $display("FAIL active_low lvl/prs/rel: got %b expected %b at %0t",
                         {lvl_al, prs_al, rel_al}, e, $time);
            end
            n_checks++;
            if ({lvl_ah, prs_ah, rel_ah} !== e) begin
                n_errors++;
                $display("FAIL active_high lvl/prs/rel: got %b expected %b at %0t",
                         {lvl_ah, prs_ah, rel_ah}, e, $time);
            end
        end
    end

    initial begin
        key_p = 1'b0;
        reset = 1'b1;
        m_h1 = 1'b0; m_h2 = 1'b0; m_level = 1'b0; m_run = 0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        hold(1'b0, 20);
        // clean press, clean release
        hold(1'b1, 12);
        hold(1'b0, 12);
        // bounce while released
        hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 10);
        // press, short release glitch, then release
        hold(1'b1, 12); hold(1'b0, 3); hold(1'b1, 10); hold(1'b0, 12);
        // reset during PRESS_WAIT while the button stays held
        hold(1'b1, 6);
        drive(1'b1, 1'b1);
        hold(1'b1, 12);
        hold(1'b0, 12);
        // randomized activity with occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            logic p;
            int   len;
            p   = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 5);
            if ($urandom_range(0, 39) == 0) drive(p, 1'b1);
            hold(p, len);
        end
        hold(1'b0, 12);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_debounce_sync.md
Name: key_debounce_sync

Overview:
- Conditions one raw push-button input before it reaches the Avalon PIO input port that exposes the button state to the NIOS II software.
- Synchronizes the asynchronous pin into the `clk` domain with a 2-FF synchronizer.
- Normalizes polarity and removes contact bounce with a counter-qualified FSM.
- Outputs a clean level for the PIO `in_port`, plus single-cycle press and release strobes for hardware consumers.

Parameters:
- DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a new state (10 ms at 50 MHz). Legal range is ≥ 1.
- CNT_W, default 20, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
- ACTIVE_LOW, default 1. When 1, a raw 0 means pressed (board KEY pins). When 0, a raw 1 means pressed.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- key_raw  in  1  asynchronous button pin.
- key_level  out  1  debounced state, 1 = pressed. Drives the PIO `in_port`.
- key_press  out  1  one-cycle strobe on an accepted press.
- key_release  out  1  one-cycle strobe on an accepted release.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is `clk` and the reset port is `reset`.
- All state is updated on the rising edge of `clk` only. `reset` is sampled on that edge and takes priority over all other logic.
- Reset values:
  - Synchronizer flops are set to the released raw value (1 if ACTIVE_LOW, else 0).
  - FSM state = RELEASED, cnt = 0.
  - key_level = 0, key_press = 0, key_release = 0.
- Synchronizer: `sync1 <= key_raw`, `sync2 <= sync1`. The FSM uses only `sync2`.
- Normalized signal: `pressed = ACTIVE_LOW ? ~sync2 : sync2`. Combinational from `sync2`, no extra register.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED:
    - If `pressed`, go to PRESS_WAIT and set cnt = 0.
    - Otherwise stay.
  - PRESS_WAIT:
    - If `!pressed`, return to RELEASED (bounce abort). cnt = 0; no strobe; key_level stays 0.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED and register key_level = 1 and key_press = 1.
    - Else cnt = cnt + 1.
  - PRESSED:
    - If `!pressed`, go to RELEASE_WAIT and set cnt = 0.
    - Otherwise stay.
  - RELEASE_WAIT:
    - If `pressed`, return to PRESSED (bounce abort). cnt = 0; no strobe; key_level stays 1.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to RELEASED and register key_level = 0 and key_release = 1.
    - Else cnt = cnt + 1.
- Strobes:
  - key_press and key_release are registered. Each is high for exactly the one cycle following the accepting edge, coincident with the key_level change.
  - Both are 0 in every other cycle and are never high together.
- Latency: when key_raw changes and then stays stable, key_level changes at the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the new raw value as edge 1. This is 2 synchronizer cycles, 1 FSM entry cycle and DEBOUNCE_CYCLES qualification cycles.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - Is held at 0 in RELEASED and PRESSED.
- Reset mid-operation: a reset asserted during a WAIT state discards the pending change, clears everything to the reset values, and produces no strobe. Coming out of reset with the button already held yields an accepted press DEBOUNCE_CYCLES+3 cycles later.
- Glitch rule: any input pulse shorter than DEBOUNCE_CYCLES cycles, measured at `sync2`, produces no change on any output.
- Illegal FSM encodings recover to RELEASED on the next edge with key_level = 0.

Test Plan:
- Sim parameters: DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
- Reset release: hold reset for 3 cycles with key_raw=1, then release → key_level=0, key_press=0, key_release=0 for 20 cycles; cnt stays 0.
- Clean press: drive key_raw 1→0 and hold → key_level rises at edge 7 after the change; key_press=1 for exactly that one cycle; key_release stays 0.
- Bounce rejection: from released, drive key_raw low for 3 cycles, high for 2, low for 2, high → no output changes; FSM ends in RELEASED.
- Clean release after a press: drive key_raw 0→1 and hold → key_level falls at edge 7; key_release=1 for exactly one cycle. A 3-cycle low glitch while pressed causes no key_press and no key_release.
- Reset mid-wait: press, then assert reset at edge 4 of PRESS_WAIT for 1 cycle while key_raw stays 0 → no strobe during reset; key_level=0; key_press fires 7 cycles after reset deasserts.
- Polarity: with ACTIVE_LOW=0, repeat the clean-press case with key_raw 0→1 → same timing, key_level=1, key_press pulses once.
